// File: rtl/button_reader.sv
// ---------------------------------------------------------------------------
// button_reader : synchronise, debounce and classify active-low push buttons
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module button_reader #(
   parameter int NUM_BTN         = 2,
   parameter int DEBOUNCE_CYCLES = 24000,
   parameter int LONG_CYCLES     = 12000000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn_n,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] press_pulse,
   output logic [NUM_BTN-1:0] release_pulse,
   output logic [NUM_BTN-1:0] long_pulse,
   output logic               btn_any
);

   localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_W = $clog2(LONG_CYCLES);

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
   // long_pulse is registered, so it is launched on the edge hold_cnt reaches its last value
   localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 2);

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_HELD         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } state_t;

   logic [NUM_BTN-1:0] sync_meta;
   logic [NUM_BTN-1:0] sync_out;
   logic [NUM_BTN-1:0] pressed;
   logic [NUM_BTN-1:0] press_ok;
   logic [NUM_BTN-1:0] release_ok;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_meta <= '1;
         sync_out  <= '1;
      end else begin
         sync_meta <= btn_n;
         sync_out  <= sync_meta;
      end
   end

   assign pressed = ~sync_out;

   generate
      for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
         state_t              state;
         logic [DEB_W-1:0]    deb_cnt;
         logic [HOLD_W-1:0]   hold_cnt;
         logic                long_done;
         logic                level;
         logic                press_q;
         logic                release_q;
         logic                long_q;

         assign press_ok[i]   = (state == ST_PRESS_WAIT)   &&  pressed[i] && (deb_cnt == DEB_LAST);
         assign release_ok[i] = (state == ST_RELEASE_WAIT) && !pressed[i] && (deb_cnt == DEB_LAST);

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               state     <= ST_IDLE;
               deb_cnt   <= '0;
               hold_cnt  <= '0;
               long_done <= 1'b0;
               level     <= 1'b0;
               press_q   <= 1'b0;
               release_q <= 1'b0;
               long_q    <= 1'b0;
            end else begin
               press_q   <= 1'b0;
               release_q <= 1'b0;
               long_q    <= 1'b0;

               // Hold timing runs through release bounces so a long press is not restarted
               if (state == ST_HELD || state == ST_RELEASE_WAIT) begin
                  if (hold_cnt != HOLD_LAST) begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
                  if (hold_cnt == HOLD_FIRE && !long_done) begin
                     long_q    <= 1'b1;
                     long_done <= 1'b1;
                  end
               end

               case (state)
                  ST_IDLE: begin
                     if (pressed[i]) begin
                        state   <= ST_PRESS_WAIT;
                        deb_cnt <= DEB_W'(1);
                     end else begin
                        deb_cnt <= '0;
                     end
                  end
                  ST_PRESS_WAIT: begin
                     if (!pressed[i]) begin
                        state   <= ST_IDLE;
                        deb_cnt <= '0;
                     end else if (press_ok[i]) begin
                        state    <= ST_HELD;
                        press_q  <= 1'b1;
                        level    <= 1'b1;
                        hold_cnt <= '0;
                        deb_cnt  <= '0;
                     end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                     end
                  end
                  ST_HELD: begin
                     if (!pressed[i]) begin
                        state   <= ST_RELEASE_WAIT;
                        deb_cnt <= DEB_W'(1);
                     end
                  end
                  ST_RELEASE_WAIT: begin
                     if (pressed[i]) begin
                        state   <= ST_HELD;
                        deb_cnt <= '0;
                     end else if (release_ok[i]) begin
                        state     <= ST_IDLE;
                        release_q <= 1'b1;
                        level     <= 1'b0;
                        hold_cnt  <= '0;
                        long_done <= 1'b0;
                        deb_cnt   <= '0;
                     end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                     end
                  end
                  default: begin
                     state   <= ST_IDLE;
                     deb_cnt <= '0;
                  end
               endcase
            end
         end

         assign btn_level[i]     = level;
         assign press_pulse[i]   = press_q;
         assign release_pulse[i] = release_q;
         assign long_pulse[i]    = long_q;
      end
   endgenerate

   // Built from next-state levels so btn_any changes on the same edge as btn_level
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         btn_any <= 1'b0;
      end else begin
         btn_any <= |((btn_level | press_ok) & ~release_ok);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_button_reader.sv
// ---------------------------------------------------------------------------
// tb_button_reader : scoreboard bench for button_reader (D=4, L=20, 2 buttons)
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_button_reader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] btn_n;
   logic [1:0] btn_level;
   logic [1:0] press_pulse;
   logic [1:0] release_pulse;
   logic [1:0] long_pulse;
   logic       btn_any;

   button_reader #(
      .NUM_BTN         (2),
      .DEBOUNCE_CYCLES (4),
      .LONG_CYCLES     (20)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .btn_n         (btn_n),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse),
      .btn_any       (btn_any)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passed = 0;
   bit done   = 1'b0;

   typedef struct {
      int         cyc;
      logic [1:0] pr;
      logic [1:0] rl;
      logic [1:0] lg;
   } pev_t;

   typedef struct {
      int         cyc;
      logic [1:0] lvl;
   } lev_t;

   pev_t pq[$];
   lev_t lq[$];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
      checks++;
      if (act === expv) passed++;
      else $display("FAIL %s at edge %0d: got %b, expected %b", name, cyc, act, expv);
   endtask

   function automatic void exp_pulse(input int c, input logic [1:0] pr, input logic [1:0] rl,
                                     input logic [1:0] lg);
      pev_t e;
      e.cyc = c; e.pr = pr; e.rl = rl; e.lg = lg;
      pq.push_back(e);
   endfunction

   function automatic void exp_level(input int c, input logic [1:0] lvl);
      lev_t e;
      e.cyc = c; e.lvl = lvl;
      lq.push_back(e);
   endfunction

   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: outputs registered at edge N are sampled on the following negedge
   always @(negedge clk) begin
      pev_t pe;
      lev_t le;
      if (!done && cyc >= 1) begin
         while (pq.size() > 0 && pq[0].cyc < cyc) begin
            checks++;
            $display("FAIL missed_pulse_event due at edge %0d, now edge %0d", pq[0].cyc, cyc);
            void'(pq.pop_front());
         end
         if (pq.size() > 0 && pq[0].cyc == cyc) begin
            pe = pq.pop_front();
            check("press_pulse",   {6'd0, press_pulse},   {6'd0, pe.pr});
            check("release_pulse", {6'd0, release_pulse}, {6'd0, pe.rl});
            check("long_pulse",    {6'd0, long_pulse},    {6'd0, pe.lg});
         end else begin
            check("no_pulse", {2'b00, press_pulse, release_pulse, long_pulse}, 8'd0);
         end

         while (lq.size() > 0 && lq[0].cyc < cyc) begin
            checks++;
            $display("FAIL missed_level_check due at edge %0d, now edge %0d", lq[0].cyc, cyc);
            void'(lq.pop_front());
         end
         if (lq.size() > 0 && lq[0].cyc == cyc) begin
            le = lq.pop_front();
            check("btn_level", {6'd0, btn_level}, {6'd0, le.lvl});
            check("btn_any",   {7'd0, btn_any},   {7'd0, |le.lvl});
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      btn_n = 2'b00;

      // Reset with both pads pressed; fresh press lands 6 edges after release of reset
      for (int c = 1; c <= 3; c++) exp_level(c, 2'b00);
      goto(3);
      rst_n = 1'b1;
      exp_level(8, 2'b00);
      exp_pulse(9, 2'b11, 2'b00, 2'b00);
      exp_level(9, 2'b11);

      goto(12);
      btn_n = 2'b11;
      exp_level(17, 2'b11);
      exp_pulse(18, 2'b00, 2'b11, 2'b00);
      exp_level(18, 2'b00);

      // Clean press/release on channel 0 with a long press
      goto(30);
      btn_n[0] = 1'b0;
      exp_level(35, 2'b00);
      exp_pulse(36, 2'b01, 2'b00, 2'b00);
      exp_level(36, 2'b01);
      exp_pulse(55, 2'b00, 2'b00, 2'b01);
      goto(60);
      btn_n[0] = 1'b1;
      exp_level(65, 2'b01);
      exp_pulse(66, 2'b00, 2'b01, 2'b00);
      exp_level(66, 2'b00);

      // Press bounce: never stable for 4 samples
      goto(80);
      exp_level(85, 2'b00);
      exp_level(95, 2'b00);
      exp_level(105, 2'b00);
      for (int k = 0; k < 10; k++) begin
         goto(80 + 2 * k);
         btn_n[0] = (k % 2 == 1);
      end
      btn_n[0] = 1'b1;

      // Release bounce while held; long press still fires once
      goto(110);
      btn_n[0] = 1'b0;
      exp_pulse(116, 2'b01, 2'b00, 2'b00);
      exp_level(116, 2'b01);
      exp_level(124, 2'b01);
      exp_level(125, 2'b01);
      exp_pulse(135, 2'b00, 2'b00, 2'b01);
      exp_level(135, 2'b01);
      goto(120);
      btn_n[0] = 1'b1;
      goto(122);
      btn_n[0] = 1'b0;
      goto(140);
      btn_n[0] = 1'b1;
      exp_pulse(146, 2'b00, 2'b01, 2'b00);
      exp_level(146, 2'b00);

      // Short press: no long pulse
      goto(160);
      btn_n[0] = 1'b0;
      exp_pulse(166, 2'b01, 2'b00, 2'b00);
      goto(174);
      btn_n[0] = 1'b1;
      exp_level(179, 2'b01);
      exp_pulse(180, 2'b00, 2'b01, 2'b00);
      exp_level(180, 2'b00);
      exp_level(190, 2'b00);

      // Simultaneous press, then reset during HELD
      goto(210);
      btn_n = 2'b00;
      exp_pulse(216, 2'b11, 2'b00, 2'b00);
      exp_level(216, 2'b11);
      exp_level(225, 2'b11);
      goto(225);
      rst_n = 1'b0;
      exp_level(226, 2'b00);
      exp_level(227, 2'b00);
      goto(228);
      rst_n = 1'b1;
      exp_level(233, 2'b00);
      exp_pulse(234, 2'b11, 2'b00, 2'b00);
      exp_level(234, 2'b11);
      exp_pulse(253, 2'b00, 2'b00, 2'b11);
      goto(260);
      btn_n = 2'b11;
      exp_pulse(266, 2'b00, 2'b11, 2'b00);
      exp_level(266, 2'b00);

      goto(280);
      @(negedge clk);
      #1;
      done = 1'b1;
      check("pulse_queue_empty", 8'(pq.size()), 8'd0);
      check("level_queue_empty", 8'(lq.size()), 8'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/button_reader.md
Name: button_reader

Overview:
- Input-side counterpart to the counter-driven RGB LED outputs on the iCE40 experiment boards.
- Samples NUM_BTN asynchronous, active-low push-button pads and synchronises them to the PLL-derived global clock.
- Debounces each button and emits clean level, press, release and long-press pulses for downstream logic (e.g. LED mode selection).
- Sits between the top-level pad inputs and the LED pattern logic, in the clk domain.

Parameters:
- NUM_BTN, 2, number of independent button channels (1..8).
- DEBOUNCE_CYCLES, 24000, consecutive stable synchronised samples required to accept a transition (minimum 2).
- LONG_CYCLES, 12000000, cycles a debounced press must persist before long_pulse fires. Must exceed DEBOUNCE_CYCLES.

Ports:
- clk  input  1  global-buffered system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- btn_n  input  NUM_BTN  raw pad inputs; 0 = pressed; asynchronous to clk.
- btn_level  output  NUM_BTN  debounced state; 1 = pressed.
- press_pulse  output  NUM_BTN  one-cycle pulse on accepted press.
- release_pulse  output  NUM_BTN  one-cycle pulse on accepted release.
- long_pulse  output  NUM_BTN  one-cycle pulse when press reaches LONG_CYCLES.
- btn_any  output  1  OR of btn_level.

Behaviour:
- Reset (rst_n low at posedge), one synchronous reset for all state:
  - sync flops = 1 (released); FSM = IDLE; deb_cnt = 0; hold_cnt = 0; long_done = 0.
  - All outputs = 0.
- Synchroniser:
  - Two flops per bit.
  - s = ~btn_n after 2 flops; s = 1 means pressed.
- Independent per-channel FSM: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
- Counter widths:
  - deb_cnt is $clog2(DEBOUNCE_CYCLES) bits.
  - hold_cnt is $clog2(LONG_CYCLES) bits.
  - hold_cnt saturates and never wraps.
- IDLE:
  - s = 1 -> PRESS_WAIT, deb_cnt = 1.
  - Otherwise stay, deb_cnt = 0.
- PRESS_WAIT:
  - s = 0 -> IDLE, deb_cnt = 0. This is a bounce; no pulse.
  - deb_cnt == DEBOUNCE_CYCLES-1 with s = 1 -> HELD:
    - press_pulse = 1 for exactly one cycle.
    - btn_level = 1.
    - hold_cnt = 0, deb_cnt = 0.
  - Otherwise deb_cnt++.
- HELD:
  - hold_cnt++ while below LONG_CYCLES-1.
  - When hold_cnt == LONG_CYCLES-1 and long_done = 0: long_pulse = 1 for one cycle, long_done = 1.
  - s = 0 -> RELEASE_WAIT, deb_cnt = 1. hold_cnt keeps counting; a long_pulse falling due that cycle is still issued.
- RELEASE_WAIT:
  - hold_cnt keeps counting, and long_pulse may fire here.
  - s = 1 -> HELD, deb_cnt = 0. Bounce; btn_level stays 1; no pulses.
  - deb_cnt == DEBOUNCE_CYCLES-1 with s = 0 -> IDLE:
    - release_pulse = 1 for one cycle.
    - btn_level = 0.
    - hold_cnt = 0, long_done = 0.
  - Otherwise deb_cnt++.
- Latency (clean edge, pad stable):
  - Pad fall sampled at edge E0; press_pulse and btn_level rise at edge E0+DEBOUNCE_CYCLES+2.
  - Release is symmetric.
  - long_pulse occurs LONG_CYCLES-1 edges after press_pulse.
- Output pulse rules:
  - press_pulse, release_pulse and long_pulse are registered and never high in consecutive cycles on the same channel.
  - press_pulse and release_pulse are never high together on one channel.
  - long_pulse fires at most once per press.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses in the same cycle.
- btn_any is registered, same cycle as btn_level.
- Reset mid-operation (any state):
  - Returns to IDLE with all outputs 0 on the next edge.
  - No release_pulse is generated for a button held through reset.
  - A button still held after reset deasserts produces a fresh press_pulse after the full debounce (DEBOUNCE_CYCLES+2).

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, NUM_BTN=2):
- Reset:
  - Stimulus: rst_n=0 for 3 cycles with btn_n=2'b00.
  - Required: all outputs 0 during reset.
  - Required: after rst_n=1, press_pulse[1:0]=2'b11 at edge 6 and btn_level=2'b11 from then on.
- Clean press/release ch0:
  - Stimulus: btn_n[0] low at edge 10, high at edge 40.
  - Required: press_pulse[0] high only at edge 16; long_pulse[0] high only at edge 35.
  - Required: release_pulse[0] high only at edge 46; btn_level[0] high over edges 16..45.
- Bounce rejection:
  - Stimulus: btn_n[0] toggled low/high every 2 cycles for 20 cycles, then left high.
  - Required: no pulses; btn_level[0]=0 throughout.
- Release bounce:
  - Stimulus: while held, btn_n[0] high for 2 cycles, then low again.
  - Required: no release_pulse; btn_level[0] stays 1; long_pulse still fires exactly once.
- Short press:
  - Stimulus: press held 8 cycles after acceptance.
  - Required: press_pulse and release_pulse exactly once each; long_pulse never fires.
- Simultaneous channels and reset mid-hold:
  - Stimulus: both buttons pressed at the same edge.
  - Required: press_pulse=2'b11 in the same cycle.
  - Stimulus: rst_n low during HELD.
  - Required: outputs 0 next cycle and no release_pulse.
